// File: rtl/keypad_hex_entry_pkg.sv
// Shared types and constants for the matrix keypad hex entry block.
// The keymap is indexed by {row, col} and returns the printed hex legend.
package keypad_pkg;

  localparam int COLS = 4;
  localparam int ROWS = 4;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_RELEASE
  } key_state_e;

  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col}];
  endfunction

endpackage

// File: rtl/keypad_hex_entry_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to all ones, the idle level of the pulled-up rows.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner: column scan, press/release debounce, hex encode,
// and a shift register of the most recent digits for the core to read.
module keypad_hex_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 8,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int DIGITS         = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ROWS-1:0]     row_i,
  output logic [COLS-1:0]     col_o,
  input  logic                clr_i,
  output logic                key_valid_o,
  output logic [3:0]          key_code_o,
  output logic [4*DIGITS-1:0] value_o
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int VW = 4 * DIGITS;

  logic [ROWS-1:0] row_sync;
  key_state_e      state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      low_row;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      key_code_q, key_code_d;
  logic [VW-1:0]   value_q, value_d;
  logic            tick;
  logic            any_low;
  logic            cnt_done;

  keypad_sync #(.WIDTH(ROWS)) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (row_i),
    .sync_o  (row_sync)
  );

  assign tick     = (dwell_q == DW'(SCAN_DIV - 1));
  assign any_low  = ~&row_sync;
  assign cnt_done = ((cnt_q + CW'(1)) == CW'(DEBOUNCE_SCANS));

  // Lowest-indexed low row wins when several keys share the column.
  always_comb begin
    low_row = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!row_sync[i]) low_row = 2'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    key_code_d = key_code_q;
    dwell_d    = tick ? '0 : dwell_q + DW'(1);

    case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (any_low) begin
            row_d = low_row;
            cnt_d = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_d    = ST_EMIT;
              key_code_d = key_map(low_row, col_q);
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (any_low && (low_row == row_q)) begin
            if (cnt_done) begin
              state_d    = ST_EMIT;
              cnt_d      = '0;
              key_code_d = key_map(row_q, col_q);
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
            cnt_d   = '0;
          end
        end
      end
      ST_EMIT: begin
        state_d = ST_RELEASE;
        cnt_d   = '0;
      end
      ST_RELEASE: begin
        // A held key keeps the counter at zero, so there is no auto-repeat.
        if (tick) begin
          if (any_low) begin
            cnt_d = '0;
          end else if (cnt_done) begin
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // A clear coinciding with a new key keeps only that key.
  always_comb begin
    value_d = value_q;
    if (state_q == ST_EMIT) value_d = (value_q << 4) | VW'(key_code_q);
    if (clr_i) value_d = (state_q == ST_EMIT) ? VW'(key_code_q) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_SCAN;
      col_q      <= 2'd0;
      row_q      <= 2'd0;
      dwell_q    <= '0;
      cnt_q      <= '0;
      key_code_q <= 4'd0;
      value_q    <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
      value_q    <= value_d;
    end
  end

  assign col_o       = ~(COLS'(1) << col_q);
  assign key_valid_o = (state_q == ST_EMIT);
  assign key_code_o  = key_code_q;
  assign value_o     = value_q;

endmodule

// File: doc/keypad_hex_entry.md
Name: keypad_hex_entry

Overview:
- Scans a 4x4 matrix hex keypad, debounces it, and encodes each confirmed press into a 4-bit hex code.
- Keeps a shift register of the most recent hex digits as a word for the core to read.
- It is the input-side counterpart of the 7-segment display path. Keys in, hex digits out to the core, against hex digits in, segments out to the displays.
- Sits in the SoC beside the core on the divided clock domain.

Parameters:
- SCAN_DIV, 8: clock cycles per column dwell; row sampling occurs on the last cycle of each dwell. Must be >= 3.
- DEBOUNCE_SCANS, 4: consecutive matching samples required to accept a press or a release. Must be >= 1.
- DIGITS, 8: hex digits held in value_o.

Ports:
- clk_i  in  1  system clock (divided clock)
- rst_i  in  1  asynchronous, active-high reset
- row_i  in  4  keypad rows, active-low, externally pulled up, asynchronous
- col_o  out  4  keypad column drive, active-low, one-hot-zero
- clr_i  in  1  synchronous clear of value_o, from core
- key_valid_o  out  1  one-cycle pulse per accepted key
- key_code_o  out  4  hex code of last accepted key, held until next key
- value_o  out  4*DIGITS  accumulated digits, newest in [3:0]

Behaviour:
- Reset values: col_o=4'b1110, key_valid_o=0, key_code_o=0, value_o=0. FSM goes to SCAN, column index 0, all counters 0. Reset is asynchronous and aborts any state immediately.
- Synchronization: row_i passes through a 2-flop synchronizer. Only synchronized rows are sampled. Because the dwell is >= 3 cycles, rows have settled and synchronized before sampling.
- Sample tick: the dwell counter runs 0..SCAN_DIV-1 and restarts on every column change. Tick occurs at SCAN_DIV-1.
- Row selection: if several rows are low, the lowest-indexed low row is taken.
- FSM states:
  - SCAN: on tick with all rows high, advance the column (3 wraps to 0), drive the new col_o, restart dwell. On tick with any row low, latch {row, col}, set match count = 1, go to DEBOUNCE. If DEBOUNCE_SCANS = 1, go directly to EMIT instead.
  - DEBOUNCE: column held. On each tick, if the same row is low, increment match count. When count reaches DEBOUNCE_SCANS, go to EMIT. If a different row or no row is low, return to SCAN and advance the column.
  - EMIT (1 cycle): key_valid_o=1. key_code_o=map(row,col). value_o <= {value_o[4*DIGITS-5:0], code}; the oldest digit is discarded. Then go to RELEASE.
  - RELEASE: column held. Each tick with all rows high increments the release count; any low row resets it to 0. At DEBOUNCE_SCANS, go to SCAN, advance the column, clear counters. A held key never re-emits (no auto-repeat).
- Latency:
  - EMIT begins the cycle after the tick that satisfies debounce.
  - From a stable press in the scanned column, key_valid_o asserts on cycle (DEBOUNCE_SCANS-1)*SCAN_DIV + 1 after the first detecting tick.
- clr_i: value_o <= 0 next cycle. If it coincides with EMIT, value_o <= {0, code}. clr_i has no effect on the FSM or key_code_o.
- Keymap (row,col0..3):
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E,0,F,D

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum (SCAN, DEBOUNCE, EMIT, RELEASE)
  - 16-entry keymap constant indexed {row,col}
  - COLS=4 and ROWS=4
- One sub-module, keypad_sync: 2-flop synchronizer for row_i, width-parameterized.
- Scan/debounce FSM and the digit shift register are in the top module.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3, DIGITS=8.
1. Reset with no key: col_o sequence is 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; key_valid_o stays 0; value_o=0.
2. Hold row1 low while col1 is driven, then release: exactly one key_valid_o pulse, key_code_o=5, value_o=0x00000005; the scan resumes only after 3 high samples.
3. Enter 1,2,3,A,4,5,6,B,7: value_o ends at 0x23A456B7, showing the oldest digit discarded.
4. Row bounces, low on one sample, high on the next, during debounce: no pulse; scanning advances to the next column.
5. Press row3 and row0 together on col3: key_code_o=A (lowest row wins); assert clr_i in the EMIT cycle: value_o=0x0000000A.
6. Assert rst_i during RELEASE with the key held: outputs return to reset values immediately; after rst_i deasserts, the still-held key is re-detected and emitted once.
